instr_decode_issue: RTL

//  RV32I decode/issue stage sitting directly upstream of register_system. Accepts a fetched

---
 rtl/instr_decode_issue.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/instr_decode_issue.sv
// instr_decode_issue: RV32I decode/issue stage with a 32-entry busy scoreboard.
// The FSM moves IDLE -> CHECK -> ISSUE -> IDLE.
// In CHECK it waits for RAW hazards to clear, then drives the register-file
// read controls and presents the decoded op to execute.
// Optional feature macro: DEC_ILLEGAL_TRAP_EN.
//   Defined: an unknown opcode issues with out_illegal=1.
//   Undefined: an unknown opcode issues as a NOP and out_illegal is tied to 0.
module instr_decode_issue #(
  parameter int XLEN = 32,
  parameter int REGW = 5,
  parameter int NREG = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic [REGW-1:0] selRS1,
  output logic [REGW-1:0] selRS2,
  output logic            read_en,
  output logic            reg_select,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [6:0]      out_opcode,
  output logic [2:0]      out_funct3,
  output logic [6:0]      out_funct7,
  output logic [REGW-1:0] out_rd,
  output logic            out_rdwrite,
  output logic [XLEN-1:0] out_imm,
  output logic [XLEN-1:0] out_pc,
  output logic            out_illegal,
  input  logic            wb_valid,
  input  logic [REGW-1:0] wb_rd,
  output logic [NREG-1:0] busy_mask,
  output logic            stall
);

  typedef enum logic [1:0] {IDLE = 2'd0, CHECK = 2'd1, ISSUE = 2'd2} state_t;

  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_MISC   = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  state_t          state, state_next;
  logic [XLEN-1:0] instr_reg, pc_reg;
  logic [NREG-1:0] busy_reg, busy_next;

  logic [6:0]      opcode;
  logic [REGW-1:0] rs1, rs2, rd;
  logic            use_rs1, use_rs2, writes_rd;
  logic            rdwrite, hazard, active, capture;
  logic [XLEN-1:0] imm;

  assign opcode = instr_reg[6:0];
  assign rd     = instr_reg[11:7];
  assign rs1    = instr_reg[19:15];
  assign rs2    = instr_reg[24:20];

  // Decode which operands the op reads and which immediate format it carries.
  // Unknown opcodes read nothing and write nothing.
  always_comb begin
    use_rs1   = 1'b0;
    use_rs2   = 1'b0;
    writes_rd = 1'b0;
    imm       = '0;
    case (opcode)
      OP_OP: begin
        use_rs1   = 1'b1;
        use_rs2   = 1'b1;
        writes_rd = 1'b1;
      end
      OP_IMM, OP_LOAD, OP_JALR: begin
        use_rs1   = 1'b1;
        writes_rd = 1'b1;
        imm       = {{20{instr_reg[31]}}, instr_reg[31:20]};
      end
      OP_STORE: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        imm     = {{20{instr_reg[31]}}, instr_reg[31:25], instr_reg[11:7]};
      end
      OP_BRANCH: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        imm     = {{19{instr_reg[31]}}, instr_reg[31], instr_reg[7],
                   instr_reg[30:25], instr_reg[11:8], 1'b0};
      end
      OP_LUI, OP_AUIPC: begin
        writes_rd = 1'b1;
        imm       = {instr_reg[31:12], 12'h000};
      end
      OP_JAL: begin
        writes_rd = 1'b1;
        imm       = {{11{instr_reg[31]}}, instr_reg[31], instr_reg[19:12],
                     instr_reg[20], instr_reg[30:21], 1'b0};
      end
      OP_MISC, OP_SYSTEM: begin
        imm = {{20{instr_reg[31]}}, instr_reg[31:20]};
      end
      default: ;
    endcase
  end

  assign rdwrite = writes_rd && (rd != '0);
  assign hazard  = (use_rs1 && busy_reg[rs1]) || (use_rs2 && busy_reg[rs2]);
  assign active  = (state == CHECK) || (state == ISSUE);

  // The FSM selects the next state and raises capture when a new instruction is latched.
  always_comb begin
    state_next = state;
    capture    = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid) begin
          capture    = 1'b1;
          state_next = CHECK;
        end
      end
      CHECK: begin
        if (!hazard) state_next = ISSUE;
      end
      ISSUE: begin
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Scoreboard update: a writeback clears its bit, an issuing op sets its bit,
  // and the set wins when both hit the same register. x0 is never busy.
  always_comb begin
    busy_next = busy_reg;
    if (wb_valid && (wb_rd != '0)) busy_next[wb_rd] = 1'b0;
    if ((state == CHECK) && !hazard && rdwrite) busy_next[rd] = 1'b1;
    busy_next[0] = 1'b0;
  end

  // State, held instruction/PC and scoreboard registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      instr_reg <= '0;
      pc_reg    <= '0;
      busy_reg  <= '0;
    end else begin
      state    <= state_next;
      busy_reg <= busy_next;
      if (capture) begin
        instr_reg <= in_instr;
        pc_reg    <= in_pc;
      end
    end
  end

  assign in_ready    = (state == IDLE);
  assign out_valid   = (state == ISSUE);
  assign stall       = (state == CHECK) && hazard;
  assign selRS1      = (active && use_rs1) ? rs1 : '0;
  assign selRS2      = (active && use_rs2) ? rs2 : '0;
  assign read_en     = active && (use_rs1 || use_rs2);
  assign reg_select  = active && use_rs2;
  assign out_opcode  = opcode;
  assign out_funct3  = instr_reg[14:12];
  assign out_funct7  = instr_reg[31:25];
  assign out_rd      = rd;
  assign out_rdwrite = rdwrite;
  assign out_imm     = imm;
  assign out_pc      = pc_reg;
  assign busy_mask   = busy_reg;

`ifdef DEC_ILLEGAL_TRAP_EN
  assign out_illegal = active && !(opcode inside {OP_OP, OP_IMM, OP_LOAD, OP_JALR,
                       OP_STORE, OP_BRANCH, OP_LUI, OP_AUIPC, OP_JAL, OP_MISC, OP_SYSTEM});
`else
  assign out_illegal = 1'b0;
`endif

endmodule
